branch_predict_update: RTL and testbench

Bimodal branch predictor with resolution logic.
- Supplies a taken/not-taken prediction to fetch.
- Sits directly downstream of the decode-stage branch compare unit and consumes its resolved taken outcome.
- Trains a table of 2-bit saturating counters, detects mispredictions, and issues a registered flush/redirect to fetch.
- Suppresses the wrong-path resolutions that follow a flush.

---
 rtl/branch_predict_update.sv | 138 +++++++++++++
 tb/tb_branch_predict_update.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_update.sv
// Bimodal branch predictor: 2-bit saturating counter table, misprediction
// detection, registered flush/redirect and a post-flush squash window.
module branch_predict_update #(
  parameter int         INDEX_BITS    = 6,
  parameter int         SQUASH_CYCLES = 1,     // 1..7
  parameter logic [1:0] CTR_INIT      = 2'b01
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Fetch_PC,
  input  logic        Fetch_Valid,
  output logic        Pred_Taken,
  input  logic        Resolve_Valid,
  input  logic        Resolve_IsBranch,
  input  logic [31:0] Resolve_PC,
  input  logic        Resolve_Taken,
  input  logic        Resolve_Pred,
  input  logic [31:0] Resolve_Target,
  input  logic [31:0] Resolve_FallThru,
  output logic        Flush,
  output logic [31:0] Redirect_PC,
  output logic [31:0] Branch_Count,
  output logic [31:0] Mispredict_Count,
  output logic [1:0]  State_Dbg
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_SQUASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sq_cnt_q, sq_cnt_d;
  logic        flush_q;
  logic [31:0] redirect_q;
  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;
  logic [1:0]  table_q [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] res_idx;
  logic                  accept;
  logic                  train;
  logic                  mis;
  logic [1:0]            ctr_cur;
  logic [1:0]            ctr_next;
  logic                  unused_bits;

  assign fetch_idx = Fetch_PC[INDEX_BITS+1:2];
  assign res_idx   = Resolve_PC[INDEX_BITS+1:2];

  // Only the index bits of either PC matter; the rest are deliberately ignored.
  assign unused_bits = ^{Fetch_PC[31:INDEX_BITS+2], Fetch_PC[1:0],
                         Resolve_PC[31:INDEX_BITS+2], Resolve_PC[1:0]};

  // Table read has no write bypass: an update lands at the edge and is seen after it.
  assign Pred_Taken = table_q[fetch_idx][1] & Fetch_Valid;

  assign accept  = Resolve_Valid & (state_q != S_SQUASH);
  assign train   = accept & Resolve_IsBranch;
  assign mis     = accept & (Resolve_Taken != Resolve_Pred);
  assign ctr_cur = table_q[res_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (Resolve_Taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
    end else if (train) begin
      table_q[res_idx] <= ctr_next;
    end
  end

  // A resolve in the FLUSH cycle is still accepted, so FLUSH can re-enter itself.
  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mis) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (mis) begin
          state_d = S_FLUSH;
        end else begin
          state_d  = S_SQUASH;
          sq_cnt_d = 3'(SQUASH_CYCLES);
        end
      end
      S_SQUASH: begin
        sq_cnt_d = sq_cnt_q - 3'd1;
        if (sq_cnt_q <= 3'd1) begin
          state_d  = S_IDLE;
          sq_cnt_d = 3'd0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        sq_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      sq_cnt_q   <= 3'd0;
      flush_q    <= 1'b0;
      redirect_q <= 32'd0;
      br_cnt_q   <= 32'd0;
      mis_cnt_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      flush_q  <= mis;
      if (mis) redirect_q <= Resolve_Taken ? Resolve_Target : Resolve_FallThru;
      if (train) br_cnt_q <= br_cnt_q + 32'd1;
      if (mis) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign Flush            = flush_q;
  assign Redirect_PC      = redirect_q;
  assign Branch_Count     = br_cnt_q;
  assign Mispredict_Count = mis_cnt_q;
  assign State_Dbg        = state_q;

endmodule

// File: tb/tb_branch_predict_update.sv
// Directed bench for branch_predict_update: flush events are checked by a
// scoreboard monitor; predictions, counts and state are checked inline.
module tb_branch_predict_update;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        pred_taken;
  logic        res_valid;
  logic        res_is_br;
  logic [31:0] res_pc;
  logic        res_taken;
  logic        res_pred;
  logic [31:0] res_target;
  logic [31:0] res_fallthru;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mis_count;
  logic [1:0]  state_dbg;

  logic [95:0] exp_q[$];
  int          n_checks;
  int          n_fails;
  logic [31:0] exp_br;
  logic [31:0] exp_mis;

  branch_predict_update dut (
    .CLK              (clk),
    .RESET            (rst),
    .Fetch_PC         (fetch_pc),
    .Fetch_Valid      (fetch_valid),
    .Pred_Taken       (pred_taken),
    .Resolve_Valid    (res_valid),
    .Resolve_IsBranch (res_is_br),
    .Resolve_PC       (res_pc),
    .Resolve_Taken    (res_taken),
    .Resolve_Pred     (res_pred),
    .Resolve_Target   (res_target),
    .Resolve_FallThru (res_fallthru),
    .Flush            (flush),
    .Redirect_PC      (redirect_pc),
    .Branch_Count     (br_count),
    .Mispredict_Count (mis_count),
    .State_Dbg        (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic idle(input int n);
    res_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resolve(input logic is_br, input logic [31:0] pc, input logic tk,
                         input logic pr, input logic [31:0] tgt, input logic [31:0] ft,
                         input bit acc, input bit sb);
    res_valid    = 1'b1;
    res_is_br    = is_br;
    res_pc       = pc;
    res_taken    = tk;
    res_pred     = pr;
    res_target   = tgt;
    res_fallthru = ft;
    if (acc) begin
      if (is_br) exp_br++;
      if (tk != pr) begin
        exp_mis++;
        if (sb) exp_q.push_back({(tk ? tgt : ft), exp_mis, exp_br});
      end
    end
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
    fetch_pc    = pc;
    fetch_valid = 1'b1;
    #1;
    check(name, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  task automatic check_counts(input string name);
    check({name, "_br"}, br_count, exp_br);
    check({name, "_mis"}, mis_count, exp_mis);
  endtask

  initial begin
    logic [95:0] got;
    logic [95:0] want;
    n_checks = 0; n_fails = 0; exp_br = 0; exp_mis = 0;
    rst = 1'b1; fetch_pc = 32'd0; fetch_valid = 1'b0;
    res_valid = 1'b0; res_is_br = 1'b0; res_pc = 32'd0; res_taken = 1'b0;
    res_pred = 1'b0; res_target = 32'd0; res_fallthru = 32'd0;

    // Scoreboard monitor: every Flush pulse must match the oldest expected entry.
    fork
      forever begin
        @(negedge clk);
        if (!rst && flush) begin
          if (exp_q.size() == 0) begin
            check("unexpected_flush", {31'd0, flush}, 32'd0);
          end else begin
            want = exp_q.pop_front();
            got  = {redirect_pc, mis_count, br_count};
            check("sb_redirect", got[95:64], want[95:64]);
            check("sb_mis_count", got[63:32], want[63:32]);
            check("sb_br_count", got[31:0], want[31:0]);
          end
        end
      end
    join_none

    // Reset state
    #2;
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check_counts("rst");
    check_pred("rst_pred_100", 32'h100, 1'b0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Train and mispredict: 01 -> 10, flush to target 0x200
    resolve(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h108, 1'b1, 1'b1);
    check_pred("pred_100_after_train", 32'h100, 1'b1);
    idle(2);
    resolve(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h108, 1'b1, 1'b1);
    check_counts("after_second");

    // Saturation at 11, then one not-taken -> 10
    repeat (4) resolve(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h108, 1'b1, 1'b1);
    resolve(1'b1, 32'h100, 1'b0, 1'b0, 32'h200, 32'h108, 1'b1, 1'b1);
    check_pred("pred_100_sat", 32'h100, 1'b1);
    check_counts("sat");

    // Saturation at 00 on index 1: 01 -> 00 -> 00 -> 01 -> 10
    repeat (2) resolve(1'b1, 32'h104, 1'b0, 1'b0, 32'h300, 32'h10c, 1'b1, 1'b1);
    resolve(1'b1, 32'h104, 1'b1, 1'b0, 32'h300, 32'h10c, 1'b1, 1'b1);
    check_pred("pred_104_01", 32'h104, 1'b0);
    idle(2);
    resolve(1'b1, 32'h104, 1'b1, 1'b0, 32'h300, 32'h10c, 1'b1, 1'b1);
    check_pred("pred_104_10", 32'h104, 1'b1);
    idle(2);

    // Squash window: mispredict at n, ignored resolve at n+2, accepted at n+3
    resolve(1'b1, 32'h108, 1'b0, 1'b1, 32'h500, 32'h110, 1'b1, 1'b1);
    check("state_flush", {30'd0, state_dbg}, 32'd1);
    idle(1);
    check("state_squash", {30'd0, state_dbg}, 32'd2);
    resolve(1'b1, 32'h108, 1'b1, 1'b0, 32'h500, 32'h110, 1'b0, 1'b1);
    check("state_idle", {30'd0, state_dbg}, 32'd0);
    resolve(1'b1, 32'h108, 1'b1, 1'b1, 32'h500, 32'h110, 1'b1, 1'b1);
    check_pred("pred_108_after_squash", 32'h108, 1'b0);
    check_counts("squash");

    // Jumps, back to back: second one lands in the FLUSH cycle and is accepted
    resolve(1'b0, 32'h300, 1'b1, 1'b0, 32'h400, 32'h308, 1'b1, 1'b1);
    resolve(1'b0, 32'h400, 1'b1, 1'b0, 32'h500, 32'h408, 1'b1, 1'b1);
    idle(1);
    resolve(1'b1, 32'h100, 1'b1, 1'b0, 32'h600, 32'h108, 1'b0, 1'b1);
    idle(1);
    check_pred("pred_100_after_jumps", 32'h100, 1'b1);
    check_counts("jumps");

    // Aliasing: 0x100 and 0x200 share index 0 (10 -> 11)
    resolve(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h108, 1'b1, 1'b1);
    check_pred("pred_200_alias", 32'h200, 1'b1);
    fetch_valid = 1'b0;
    #1;
    check("pred_fetch_invalid", {31'd0, pred_taken}, 32'd0);

    // Asynchronous reset during the FLUSH cycle
    resolve(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 32'h108, 1'b1, 1'b0);
    check("flush_before_rst", {31'd0, flush}, 32'd1);
    #1 rst = 1'b1;
    #1;
    exp_br = 0; exp_mis = 0;
    check("midflush_rst_flush", {31'd0, flush}, 32'd0);
    check("midflush_rst_state", {30'd0, state_dbg}, 32'd0);
    check("midflush_rst_redirect", redirect_pc, 32'd0);
    check_counts("midflush_rst");
    check_pred("pred_200_after_rst", 32'h200, 1'b0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Counters restart from zero after reset
    resolve(1'b0, 32'h700, 1'b1, 1'b0, 32'h800, 32'h708, 1'b1, 1'b1);
    idle(4);
    check_counts("post_rst");
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
